// File: rtl/fifo_status_if.sv
// fifo_status_if
//   Bundles the FIFO's write/read handshake, control strobes and status
//   outputs so the FIFO and its user connect through one port.
//   master modport : the FIFO user (drives wr/rd/w_data/flush/clr_err)
//   slave modport  : the FIFO itself (drives r_data, count and all flags)
// Parameters B (word width) and W (address bits) must match the FIFO's.
interface fifo_status_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         flush;
  logic         clr_err;
  logic         wr;
  logic [B-1:0] w_data;
  logic         rd;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output flush, clr_err, wr, w_data, rd,
    input  r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr, w_data, rd,
    output r_data, empty, full, almost_empty, almost_full, count,
           overflow, underflow
  );
endinterface

// File: rtl/fifo_status.sv
// fifo_status
//   Synchronous show-ahead FIFO with occupancy count, programmable
//   almost-full/almost-empty flags, sticky overflow/underflow flags and a
//   synchronous flush. r_data always presents the head word combinationally.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears pointers, count and flags
//   bus    : fifo_status_if.slave
//            in : flush, clr_err, wr, w_data, rd
//            out: r_data, empty, full, almost_empty, almost_full, count,
//                 overflow, underflow
// Parameters
//   B word width, W address bits (DEPTH = 2**W),
//   AF_LVL almost_full threshold (count >= AF_LVL),
//   AE_LVL almost_empty threshold (count <= AE_LVL)
module fifo_status #(
  parameter int B      = 8,
  parameter int W      = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic               clk,
  input  logic               reset,
  fifo_status_if.slave       bus
);

  localparam int DEPTH = 1 << W;

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] w_ptr;
  logic [W-1:0] r_ptr;
  logic [W:0]   count_q;
  logic [W:0]   count_nxt;
  logic         empty_q;
  logic         full_q;
  logic         almost_empty_q;
  logic         almost_full_q;
  logic         overflow_q;
  logic         underflow_q;

  logic         wr_acc;
  logic         rd_acc;
  logic         ovf_evt;
  logic         udf_evt;

  // A write to a full FIFO is still taken when a pop frees the head slot on
  // the same edge. Flush suppresses both transfers for its cycle.
  always_comb begin
    wr_acc  = bus.wr & (~full_q | bus.rd) & ~bus.flush;
    rd_acc  = bus.rd & ~empty_q & ~bus.flush;
    ovf_evt = bus.wr & full_q & ~bus.rd & ~bus.flush;
    udf_evt = bus.rd & empty_q & ~bus.flush;
  end

  // Next occupancy; every flag is derived from this value so flags and count
  // always change together.
  always_comb begin
    count_nxt = count_q;
    if (bus.flush) begin
      count_nxt = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_nxt = count_q + (W+1)'(1);
        2'b01:   count_nxt = count_q - (W+1)'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  // Pointers, count and registered status flags. Error flags are sticky;
  // a new error event beats a simultaneous clr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr          <= '0;
      r_ptr          <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (bus.flush) begin
        w_ptr <= '0;
        r_ptr <= '0;
      end else begin
        if (wr_acc) w_ptr <= w_ptr + W'(1);
        if (rd_acc) r_ptr <= r_ptr + W'(1);
      end
      count_q        <= count_nxt;
      empty_q        <= (count_nxt == '0);
      full_q         <= (count_nxt == (W+1)'(DEPTH));
      almost_empty_q <= (int'(count_nxt) <= AE_LVL);
      almost_full_q  <= (int'(count_nxt) >= AF_LVL);
      overflow_q     <= ovf_evt | (overflow_q & ~bus.clr_err);
      underflow_q    <= udf_evt | (underflow_q & ~bus.clr_err);
    end
  end

  // Storage is deliberately not reset; contents are meaningless after reset
  // or flush because the pointers restart at zero.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[w_ptr] <= bus.w_data;
  end

  assign bus.r_data       = mem[r_ptr];
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_status.sv
// tb_fifo_status
//   Directed self-checking bench for fifo_status (B=8, W=4, AF_LVL=12,
//   AE_LVL=2). Expected data order comes from a queue model fed by the
//   bench's own write values; flag/count expectations are hand-computed.
`timescale 1ns/1ps
module tb_fifo_status;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [7:0] q[$];

  fifo_status_if #(.B(8), .W(4)) bus ();

  fifo_status #(.B(8), .W(4), .AF_LVL(12), .AE_LVL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr = 1'b1; bus.w_data = d;
    tick();
    bus.wr = 1'b0;
    q.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = q.pop_front();
    check_output(tag, bus.r_data, e);
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1;
    bus.flush = 0; bus.clr_err = 0; bus.wr = 0; bus.rd = 0; bus.w_data = '0;
    #23 reset = 1'b0;

    // Reset and idle
    repeat (3) tick();
    check_output("rst_empty", bus.empty, 1);
    check_output("rst_aempty", bus.almost_empty, 1);
    check_output("rst_count", bus.count, 0);
    check_output("rst_full", bus.full, 0);
    check_output("rst_afull", bus.almost_full, 0);
    check_output("rst_ovf", bus.overflow, 0);
    check_output("rst_udf", bus.underflow, 0);

    // Fill with 0x01..0x10, tracking flags at every step
    for (int i = 1; i <= 16; i++) begin
      push(8'(i));
      check_output($sformatf("fill_count%0d", i), bus.count, i);
      check_output($sformatf("fill_af%0d", i), bus.almost_full, (i >= 12) ? 1 : 0);
      check_output($sformatf("fill_ae%0d", i), bus.almost_empty, (i <= 2) ? 1 : 0);
      check_output($sformatf("fill_full%0d", i), bus.full, (i == 16) ? 1 : 0);
      check_output($sformatf("fill_empty%0d", i), bus.empty, 0);
    end

    // Write while full: ignored, overflow sticks
    bus.wr = 1'b1; bus.w_data = 8'hAA;
    tick();
    bus.wr = 1'b0;
    check_output("ovf_set", bus.overflow, 1);
    check_output("ovf_count", bus.count, 16);
    check_output("ovf_head", bus.r_data, 8'h01);
    tick();
    check_output("ovf_sticky", bus.overflow, 1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check_output("ovf_clr", bus.overflow, 0);

    // Write+read while full: both taken, no overflow
    bus.wr = 1'b1; bus.rd = 1'b1; bus.w_data = 8'hBB;
    check_output("full_wrrd_head", bus.r_data, q.pop_front());
    tick();
    bus.wr = 1'b0; bus.rd = 1'b0;
    q.push_back(8'hBB);
    check_output("full_wrrd_count", bus.count, 16);
    check_output("full_wrrd_ovf", bus.overflow, 0);
    check_output("full_wrrd_full", bus.full, 1);

    // Drain all 16 in order
    for (int i = 16; i >= 1; i--) begin
      pop_check($sformatf("drain_data%0d", i));
      check_output($sformatf("drain_count%0d", i), bus.count, i - 1);
    end
    check_output("drain_empty", bus.empty, 1);
    check_output("drain_ae", bus.almost_empty, 1);
    check_output("drain_udf", bus.underflow, 0);

    // Read on empty: underflow
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    check_output("udf_set", bus.underflow, 1);
    check_output("udf_count", bus.count, 0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check_output("udf_clr", bus.underflow, 0);

    // Write+read on empty: write only, underflow set, no stale read
    bus.wr = 1'b1; bus.rd = 1'b1; bus.w_data = 8'h55;
    tick();
    bus.wr = 1'b0; bus.rd = 1'b0;
    q.push_back(8'h55);
    check_output("ewr_count", bus.count, 1);
    check_output("ewr_data", bus.r_data, 8'h55);
    check_output("ewr_udf", bus.underflow, 1);
    check_output("ewr_empty", bus.empty, 0);

    // Pop it, then read-on-empty together with clr_err: event wins
    pop_check("ewr_pop");
    bus.rd = 1'b1; bus.clr_err = 1'b1;
    tick();
    bus.rd = 1'b0; bus.clr_err = 1'b0;
    check_output("clr_vs_evt", bus.underflow, 1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check_output("clr_final", bus.underflow, 0);

    // Count 5, then 20 cycles of simultaneous write+read
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check_output("ss_count0", bus.count, 5);
    check_output("ss_ae0", bus.almost_empty, 0);
    for (int i = 0; i < 20; i++) begin
      bus.wr = 1'b1; bus.rd = 1'b1; bus.w_data = 8'h20 + 8'(i);
      check_output($sformatf("ss_data%0d", i), bus.r_data, q.pop_front());
      tick();
      q.push_back(8'h20 + 8'(i));
      check_output($sformatf("ss_count%0d", i), bus.count, 5);
    end
    bus.wr = 1'b0; bus.rd = 1'b0;

    // Grow to 7, then flush with a concurrent write
    push(8'h40);
    push(8'h41);
    check_output("pre_flush_count", bus.count, 7);
    bus.flush = 1'b1; bus.wr = 1'b1; bus.w_data = 8'h99;
    tick();
    bus.flush = 1'b0; bus.wr = 1'b0;
    q.delete();
    check_output("flush_count", bus.count, 0);
    check_output("flush_empty", bus.empty, 1);
    check_output("flush_ae", bus.almost_empty, 1);
    check_output("flush_full", bus.full, 0);
    push(8'h77);
    check_output("post_flush_data", bus.r_data, 8'h77);
    check_output("post_flush_count", bus.count, 1);

    // Asynchronous reset between edges
    #3 reset = 1'b1;
    #1;
    check_output("async_count", bus.count, 0);
    check_output("async_empty", bus.empty, 1);
    check_output("async_ae", bus.almost_empty, 1);
    #1 reset = 1'b0;
    q.delete();
    tick();
    check_output("after_async_count", bus.count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
